// File: rtl/apb_pkg.sv
// Shared types for the APB3 fan-out bridge: FSM states, request/response payloads.
// Payload fields are sized for the widest supported bus; ports narrower than this are zero-extended.
package apb_pkg;

  localparam int unsigned APB_AW = 32;
  localparam int unsigned APB_DW = 32;
  localparam int unsigned APB_IW = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
    logic              write;
    logic [APB_IW-1:0] idx;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DW-1:0] rdata;
    logic              err;
  } apb_rsp_t;

  // Select-field width; a single slave still gets one index bit.
  function automatic int unsigned apb_idx_w(input int unsigned n);
    return (n > 32'd2) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/apb_demux_decode.sv
// Address-window decoder: slave index from the bits above the window offset,
// error when the fabric base does not match or the index has no slave behind it.
module apb_demux_decode
  import apb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH    = 32,
  parameter int unsigned           N_SLAVES      = 4,
  parameter int unsigned           SLV_ADDR_BITS = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 32'h4000_0000,
  parameter int unsigned           IDX_W         = apb_idx_w(N_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
  output logic [IDX_W-1:0]      idx,
  output logic                  dec_err
);

  localparam int unsigned TOP_LSB = SLV_ADDR_BITS + IDX_W;

  logic base_hit;
  logic idx_ok;
  logic unused_offset;

  assign idx           = paddr[SLV_ADDR_BITS +: IDX_W];
  assign unused_offset = ^paddr[SLV_ADDR_BITS-1:0];

  generate
    if (TOP_LSB < ADDR_WIDTH) begin : g_base
      assign base_hit = (paddr[ADDR_WIDTH-1:TOP_LSB] == BASE_ADDR[ADDR_WIDTH-1:TOP_LSB]);
    end else begin : g_nobase
      assign base_hit = 1'b1;
    end

    // Every index value is populated when N_SLAVES fills the index field.
    if (N_SLAVES == (32'd1 << IDX_W)) begin : g_full
      assign idx_ok = 1'b1;
    end else begin : g_partial
      assign idx_ok = (idx <= IDX_W'(N_SLAVES - 32'd1));
    end
  endgenerate

  assign dec_err = !base_hit || !idx_ok;

endmodule

// File: rtl/apb_demux.sv
// APB3 bridge: one upstream completer port fanned out to N_SLAVES requester ports,
// fully registered in both directions. Access timeout compiled in with APB_DEMUX_TIMEOUT_EN.
module apb_demux
  import apb_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           N_SLAVES       = 4,
  parameter int unsigned           SLV_ADDR_BITS  = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h4000_0000,
  parameter int unsigned           TIMEOUT_CYCLES = 255
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic [ADDR_WIDTH-1:0]          s_PADDR,
  input  logic [DATA_WIDTH-1:0]          s_PWDATA,
  input  logic                           s_PSEL,
  input  logic                           s_PENABLE,
  input  logic                           s_PWRITE,
  output logic                           s_PREADY,
  output logic [DATA_WIDTH-1:0]          s_PRDATA,
  output logic                           s_PSLVERR,
  output logic [ADDR_WIDTH-1:0]          m_PADDR,
  output logic [DATA_WIDTH-1:0]          m_PWDATA,
  output logic                           m_PWRITE,
  output logic                           m_PENABLE,
  output logic [N_SLAVES-1:0]            m_PSEL,
  input  logic [N_SLAVES-1:0]            m_PREADY,
  input  logic [N_SLAVES-1:0]            m_PSLVERR,
  input  logic [N_SLAVES*DATA_WIDTH-1:0] m_PRDATA
);

  localparam int unsigned IDX_W = apb_idx_w(N_SLAVES);

  state_e   state_q, state_d;
  apb_req_t req_q, req_d;
  apb_rsp_t rsp_q, rsp_d;

  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_err;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  setup_phase;
  logic                  access_phase;

  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  timeout;

  logic                  pready_d;
  logic [DATA_WIDTH-1:0] prdata_d;
  logic                  pslverr_d;
  logic [N_SLAVES-1:0]   msel_d;
  logic                  menable_d;
  logic                  mwrite_d;
  logic [ADDR_WIDTH-1:0] maddr_d;
  logic [DATA_WIDTH-1:0] mwdata_d;

  apb_demux_decode #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .N_SLAVES      (N_SLAVES),
    .SLV_ADDR_BITS (SLV_ADDR_BITS),
    .BASE_ADDR     (BASE_ADDR),
    .IDX_W         (IDX_W)
  ) u_decode (
    .paddr   (s_PADDR),
    .idx     (dec_idx),
    .dec_err (dec_err)
  );

  assign offset       = ADDR_WIDTH'(s_PADDR[SLV_ADDR_BITS-1:0]);
  assign setup_phase  = s_PSEL && !s_PENABLE;
  assign access_phase = s_PSEL && s_PENABLE;

  // Only the addressed slave's response is looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (req_q.idx == APB_IW'(i)) begin
        sel_ready = m_PREADY[i];
        sel_err   = m_PSLVERR[i];
        sel_rdata = m_PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef APB_DEMUX_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
    end else if (state_d == ST_SETUP) begin
      cnt_q <= '0;
    end else if (state_q == ST_ACCESS && !sel_ready) begin
      cnt_q <= CNT_W'(32'(cnt_q) + 32'd1);
    end
  end

  // Fires in the access cycle that brings the count to TIMEOUT_CYCLES.
  assign timeout = (state_q == ST_ACCESS) && !sel_ready &&
                   ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the captured request and response.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    case (state_q)
      ST_IDLE: begin
        if (setup_phase) begin
          req_d.addr  = APB_AW'(offset);
          req_d.wdata = APB_DW'(s_PWDATA);
          req_d.write = s_PWRITE;
          req_d.idx   = APB_IW'(dec_idx);
          if (dec_err) begin
            rsp_d.rdata = '0;
            rsp_d.err   = 1'b1;
            state_d     = ST_RESP;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (sel_ready) begin
          rsp_d.rdata = req_q.write ? '0 : APB_DW'(sel_rdata);
          rsp_d.err   = sel_err;
          state_d     = ST_RESP;
        end else if (timeout) begin
          rsp_d.rdata = '0;
          rsp_d.err   = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        // Leave once the response has been presented, or drop it if the master went away.
        if (s_PREADY || !s_PSEL) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered port outputs, derived from the upcoming state.
  always_comb begin
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    msel_d    = '0;
    menable_d = 1'b0;
    mwrite_d  = 1'b0;
    maddr_d   = '0;
    mwdata_d  = '0;
    if (state_d == ST_RESP && access_phase) begin
      pready_d  = 1'b1;
      prdata_d  = DATA_WIDTH'(rsp_d.rdata);
      pslverr_d = rsp_d.err;
    end
    if (state_d == ST_SETUP || state_d == ST_ACCESS) begin
      msel_d    = N_SLAVES'(1) << req_d.idx;
      menable_d = (state_d == ST_ACCESS);
      mwrite_d  = req_d.write;
      maddr_d   = ADDR_WIDTH'(req_d.addr);
      mwdata_d  = DATA_WIDTH'(req_d.wdata);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      req_q     <= '0;
      rsp_q     <= '0;
      s_PREADY  <= 1'b0;
      s_PRDATA  <= '0;
      s_PSLVERR <= 1'b0;
      m_PSEL    <= '0;
      m_PENABLE <= 1'b0;
      m_PWRITE  <= 1'b0;
      m_PADDR   <= '0;
      m_PWDATA  <= '0;
    end else begin
      req_q     <= req_d;
      rsp_q     <= rsp_d;
      s_PREADY  <= pready_d;
      s_PRDATA  <= prdata_d;
      s_PSLVERR <= pslverr_d;
      m_PSEL    <= msel_d;
      m_PENABLE <= menable_d;
      m_PWRITE  <= mwrite_d;
      m_PADDR   <= maddr_d;
      m_PWDATA  <= mwdata_d;
    end
  end

endmodule

// File: tb/tb_apb_demux.sv
// Self-checking bench for apb_demux: expected upstream/downstream results are queued at
// stimulus time and popped when the transfer completes. Honours APB_DEMUX_TIMEOUT_EN.
module tb_apb_demux;

  localparam int NS = 4;

  logic          PCLK;
  logic          PRESETn;
  logic [31:0]   s_PADDR;
  logic [31:0]   s_PWDATA;
  logic          s_PSEL;
  logic          s_PENABLE;
  logic          s_PWRITE;
  logic          s_PREADY;
  logic [31:0]   s_PRDATA;
  logic          s_PSLVERR;
  logic [31:0]   m_PADDR;
  logic [31:0]   m_PWDATA;
  logic          m_PWRITE;
  logic          m_PENABLE;
  logic [NS-1:0] m_PSEL;
  logic [NS-1:0] m_PREADY;
  logic [NS-1:0] m_PSLVERR;
  logic [NS*32-1:0] m_PRDATA;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [3:0]  sel;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] slv_rdata [NS];
  int          slv_wait  [NS];
  logic        slv_err   [NS];
  logic        slv_never [NS];
  int          acc_cnt;

  apb_demux #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .N_SLAVES       (NS),
    .SLV_ADDR_BITS  (12),
    .BASE_ADDR      (32'h4000_0000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .s_PADDR   (s_PADDR),
    .s_PWDATA  (s_PWDATA),
    .s_PSEL    (s_PSEL),
    .s_PENABLE (s_PENABLE),
    .s_PWRITE  (s_PWRITE),
    .s_PREADY  (s_PREADY),
    .s_PRDATA  (s_PRDATA),
    .s_PSLVERR (s_PSLVERR),
    .m_PADDR   (m_PADDR),
    .m_PWDATA  (m_PWDATA),
    .m_PWRITE  (m_PWRITE),
    .m_PENABLE (m_PENABLE),
    .m_PSEL    (m_PSEL),
    .m_PREADY  (m_PREADY),
    .m_PSLVERR (m_PSLVERR),
    .m_PRDATA  (m_PRDATA)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Slave models: ready after slv_wait access cycles, read data always on the bus.
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) acc_cnt <= 0;
    else if (m_PENABLE && ((m_PSEL & m_PREADY) == '0)) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always_comb begin
    m_PREADY  = '0;
    m_PSLVERR = '0;
    m_PRDATA  = '0;
    for (int i = 0; i < NS; i++) begin
      m_PREADY[i]  = m_PSEL[i] && m_PENABLE && !slv_never[i] && (acc_cnt >= slv_wait[i]);
      m_PSLVERR[i] = m_PSEL[i] && m_PENABLE && !slv_never[i] && (acc_cnt >= slv_wait[i]) && slv_err[i];
      m_PRDATA[i*32 +: 32] = slv_rdata[i];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One upstream transfer starting now (T0); lat = cycle index of s_PREADY, -1 if never seen.
  task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         input int budget, output exp_t o);
    s_PSEL = 1'b1; s_PENABLE = 1'b0; s_PADDR = addr; s_PWRITE = wr; s_PWDATA = wdata;
    @(posedge PCLK); #1;
    o.sel = m_PSEL; o.paddr = m_PADDR; o.pwdata = m_PWDATA; o.pwrite = m_PWRITE;
    s_PENABLE = 1'b1;
    o.lat = 1;
    while (!s_PREADY && o.lat < budget) begin
      @(posedge PCLK); #1;
      o.lat++;
    end
    o.rdata = s_PRDATA;
    o.err   = s_PSLVERR;
    if (!s_PREADY) o.lat = -1;
    @(posedge PCLK); #1;
    s_PSEL = 1'b0; s_PENABLE = 1'b0;
  endtask

  task automatic slaves_default();
    for (int i = 0; i < NS; i++) begin
      slv_rdata[i] = 32'hFFFF_0000 | 32'(i);
      slv_wait[i]  = 0;
      slv_err[i]   = 1'b0;
      slv_never[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    s_PSEL = 1'b0; s_PENABLE = 1'b0; s_PWRITE = 1'b0; s_PADDR = '0; s_PWDATA = '0;
    slaves_default();
    repeat (2) @(posedge PCLK);
    #1;
    n_cmp++;
    if ({s_PREADY, s_PSLVERR, s_PRDATA} !== 34'd0) begin
      n_err++;
      $display("FAIL reset_upstream: got %h want 0", {s_PREADY, s_PSLVERR, s_PRDATA});
    end
    n_cmp++;
    if ({m_PSEL, m_PENABLE, m_PWRITE, m_PADDR, m_PWDATA} !== 70'd0) begin
      n_err++;
      $display("FAIL reset_downstream: got %h want 0", {m_PSEL, m_PENABLE, m_PWRITE, m_PADDR, m_PWDATA});
    end
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;
  endtask

  // Drive one transfer and check it against the head of the scoreboard.
  task automatic run_and_check(input string name, input logic [31:0] addr, input logic wr,
                               input logic [31:0] wdata, input int budget);
    exp_t o, e;
    do_xfer(addr, wr, wdata, budget, o);
    e = exp_q.pop_front();
    n_cmp++;
    if (o.lat !== e.lat || o.err !== e.err || o.rdata !== e.rdata) begin
      n_err++;
      $display("FAIL %s_upstream: got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
               name, o.lat, o.err, o.rdata, e.lat, e.err, e.rdata);
    end
    n_cmp++;
    if (o.sel !== e.sel || o.paddr !== e.paddr || o.pwdata !== e.pwdata || o.pwrite !== e.pwrite) begin
      n_err++;
      $display("FAIL %s_downstream: got sel=%b addr=%h wdata=%h wr=%b want sel=%b addr=%h wdata=%h wr=%b",
               name, o.sel, o.paddr, o.pwdata, o.pwrite, e.sel, e.paddr, e.pwdata, e.pwrite);
    end
  endtask

  task automatic test_write();
    slaves_default();
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 3, sel: 4'b0010,
                      paddr: 32'h010, pwdata: 32'hDEAD_BEEF, pwrite: 1'b1});
    run_and_check("write_s1", 32'h4000_1010, 1'b1, 32'hDEAD_BEEF, 40);
  endtask

  task automatic test_read_wait();
    slaves_default();
    slv_rdata[3] = 32'h1234_5678;
    slv_wait[3]  = 3;
    exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b0, lat: 6, sel: 4'b1000,
                      paddr: 32'h004, pwdata: 32'h0, pwrite: 1'b0});
    run_and_check("read_s3_wait3", 32'h4000_3004, 1'b0, 32'h0, 40);
  endtask

  task automatic test_decode_err();
    slaves_default();
    exp_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 2, sel: 4'b0000,
                      paddr: 32'h0, pwdata: 32'h0, pwrite: 1'b0});
    run_and_check("decode_outside", 32'h5000_0000, 1'b0, 32'h0, 40);
    exp_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 2, sel: 4'b0000,
                      paddr: 32'h0, pwdata: 32'h0, pwrite: 1'b0});
    run_and_check("decode_above_fabric", 32'h4000_4000, 1'b1, 32'h77, 40);
  endtask

  task automatic test_slverr();
    slaves_default();
    slv_rdata[2] = 32'hA5A5_0002;
    slv_err[2]   = 1'b1;
    slv_err[3]   = 1'b1;
    exp_q.push_back('{rdata: 32'hA5A5_0002, err: 1'b1, lat: 3, sel: 4'b0100,
                      paddr: 32'h008, pwdata: 32'h0, pwrite: 1'b0});
    run_and_check("slverr_s2", 32'h4000_2008, 1'b0, 32'h0, 40);
  endtask

  task automatic test_timeout();
    slaves_default();
    slv_never[0] = 1'b1;
    slv_rdata[0] = 32'hCAFE_F00D;
`ifdef APB_DEMUX_TIMEOUT_EN
    exp_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 18, sel: 4'b0001,
                      paddr: 32'h0, pwdata: 32'h0, pwrite: 1'b0});
    run_and_check("timeout_s0", 32'h4000_0000, 1'b0, 32'h0, 40);
    n_cmp++;
    if ({m_PSEL, m_PENABLE} !== 5'b0000_0) begin
      n_err++;
      $display("FAIL timeout_released: got sel=%b en=%b want 0", m_PSEL, m_PENABLE);
    end
`else
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, lat: -1, sel: 4'b0001,
                      paddr: 32'h0, pwdata: 32'h0, pwrite: 1'b0});
    run_and_check("no_timeout_s0", 32'h4000_0000, 1'b0, 32'h0, 100);
    n_cmp++;
    if ({m_PSEL, m_PENABLE} !== 5'b0001_1) begin
      n_err++;
      $display("FAIL no_timeout_still_waiting: got sel=%b en=%b want sel=0001 en=1", m_PSEL, m_PENABLE);
    end
    PRESETn = 1'b0;
    #2;
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;
`endif
    slv_never[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    slaves_default();
    slv_never[1] = 1'b1;
    s_PSEL = 1'b1; s_PENABLE = 1'b0; s_PADDR = 32'h4000_1020; s_PWRITE = 1'b1; s_PWDATA = 32'h55;
    @(posedge PCLK); #1;
    s_PENABLE = 1'b1;
    @(posedge PCLK); #3;
    n_cmp++;
    if ({m_PSEL, m_PENABLE} !== 5'b0010_1) begin
      n_err++;
      $display("FAIL reset_mid_in_access: got sel=%b en=%b want sel=0010 en=1", m_PSEL, m_PENABLE);
    end
    PRESETn = 1'b0;
    #1;
    n_cmp++;
    if ({s_PREADY, s_PSLVERR, s_PRDATA, m_PSEL, m_PENABLE, m_PWRITE, m_PADDR, m_PWDATA} !== 104'd0) begin
      n_err++;
      $display("FAIL reset_mid_async: got %h want 0",
               {s_PREADY, s_PSLVERR, s_PRDATA, m_PSEL, m_PENABLE, m_PWRITE, m_PADDR, m_PWDATA});
    end
    s_PSEL = 1'b0; s_PENABLE = 1'b0;
    slv_never[1] = 1'b0;
    slv_rdata[1] = 32'h0BAD_F00D;
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;
    exp_q.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0, lat: 3, sel: 4'b0010,
                      paddr: 32'h024, pwdata: 32'h0, pwrite: 1'b0});
    run_and_check("after_reset_s1", 32'h4000_1024, 1'b0, 32'h0, 40);
  endtask

  task automatic test_back_to_back();
    slaves_default();
    slv_rdata[1] = 32'h1111_2222;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 3, sel: 4'b0001,
                      paddr: 32'hFFC, pwdata: 32'h8765_4321, pwrite: 1'b1});
    exp_q.push_back('{rdata: 32'h1111_2222, err: 1'b0, lat: 3, sel: 4'b0010,
                      paddr: 32'h000, pwdata: 32'h0, pwrite: 1'b0});
    run_and_check("b2b_s0_top", 32'h4000_0FFC, 1'b1, 32'h8765_4321, 40);
    run_and_check("b2b_s1_base", 32'h4000_1000, 1'b0, 32'h0, 40);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_decode_err();
    test_slverr();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
